// File: rtl/ifetch_sequencer.sv
// Scalar-unit fetch controller: owns the program counter, issues instruction-memory
// reads and qualifies the word that returns one cycle later.
module ifetch_sequencer #(
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              I_Start,
    input  logic [ADDR_W-1:0] I_Start_Addr,
    input  logic [ADDR_W-1:0] I_End_Addr,
    input  logic              I_Stall,
    input  logic              I_Branch,
    input  logic [ADDR_W-1:0] I_Branch_Addr,
    input  logic              I_End,
    output logic              O_IMem_Re,
    output logic [ADDR_W-1:0] O_IMem_Addr,
    output logic              O_Valid,
    output logic [ADDR_W-1:0] O_PC,
    output logic              O_Flush,
    output logic              O_Busy,
    output logic              O_Term
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        TERM = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] end_addr;
    logic [ADDR_W-1:0] end_next;
    logic              issue;
    logic              flush;

    logic              vld_p1;
    logic [ADDR_W-1:0] pc_p1;

    // Modulo-2^ADDR_W increment; the program end is matched by equality,
    // so a program that wraps through zero is legal.
    function automatic logic [ADDR_W-1:0] pc_wrap_inc(input logic [ADDR_W-1:0] a);
        return a + PC_ONE;
    endfunction

    always_comb begin
        state_next = state;
        pc_next    = pc;
        end_next   = end_addr;
        issue      = 1'b0;
        flush      = 1'b0;
        unique case (state)
            IDLE: begin
                if (I_Start) begin
                    pc_next    = I_Start_Addr;
                    end_next   = I_End_Addr;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (I_End) begin
                    state_next = TERM;
                end else if (I_Branch) begin
                    pc_next = I_Branch_Addr;
                    flush   = 1'b1;
                end else if (!I_Stall) begin
                    issue = 1'b1;
                    if (pc == end_addr) begin
                        state_next = HOLD;
                    end else begin
                        pc_next = pc_wrap_inc(pc);
                    end
                end
            end
            HOLD: begin
                // Last address already issued; wait for decode to see the end
                // or for execute to redirect us back into the program.
                if (I_End) begin
                    state_next = TERM;
                end else if (I_Branch) begin
                    pc_next    = I_Branch_Addr;
                    flush      = 1'b1;
                    state_next = RUN;
                end
            end
            TERM: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= '0;
            end_addr <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            end_addr <= end_next;
        end
    end

    // Stage p1: memory returns the word addressed in the previous cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            pc_p1  <= '0;
        end else begin
            vld_p1 <= issue;
            if (issue) begin
                pc_p1 <= pc;
            end
        end
    end

    assign O_IMem_Re   = issue;
    assign O_IMem_Addr = pc;
    // A branch or end in the return cycle squashes the arriving word.
    assign O_Valid     = vld_p1 & ~I_Branch & ~I_End & ~reset;
    assign O_PC        = pc_p1;
    assign O_Flush     = flush;
    assign O_Busy      = (state != IDLE);
    assign O_Term      = (state == TERM);

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Directed bench for ifetch_sequencer: each step drives one cycle of inputs and
// checks the outputs of that cycle against hand-computed values.
module tb_ifetch_sequencer;

    logic       clock;
    logic       reset;
    logic       I_Start;
    logic [9:0] I_Start_Addr;
    logic [9:0] I_End_Addr;
    logic       I_Stall;
    logic       I_Branch;
    logic [9:0] I_Branch_Addr;
    logic       I_End;
    logic       O_IMem_Re;
    logic [9:0] O_IMem_Addr;
    logic       O_Valid;
    logic [9:0] O_PC;
    logic       O_Flush;
    logic       O_Busy;
    logic       O_Term;

    int compared   = 0;
    int mismatched = 0;

    ifetch_sequencer #(.ADDR_W(10)) dut (
        .clock        (clock),
        .reset        (reset),
        .I_Start      (I_Start),
        .I_Start_Addr (I_Start_Addr),
        .I_End_Addr   (I_End_Addr),
        .I_Stall      (I_Stall),
        .I_Branch     (I_Branch),
        .I_Branch_Addr(I_Branch_Addr),
        .I_End        (I_End),
        .O_IMem_Re    (O_IMem_Re),
        .O_IMem_Addr  (O_IMem_Addr),
        .O_Valid      (O_Valid),
        .O_PC         (O_PC),
        .O_Flush      (O_Flush),
        .O_Busy       (O_Busy),
        .O_Term       (O_Term)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs shortly after the rising edge, then let them settle.
    task automatic step(input logic rs, input logic st, input logic [9:0] sa, input logic [9:0] ea,
                        input logic sl, input logic br, input logic [9:0] ba, input logic en);
        @(posedge clock);
        #1;
        reset = rs; I_Start = st; I_Start_Addr = sa; I_End_Addr = ea;
        I_Stall = sl; I_Branch = br; I_Branch_Addr = ba; I_End = en;
        #1;
    endtask

    task automatic quiet();
        step(1'b0, 1'b0, 10'h0, 10'h0, 1'b0, 1'b0, 10'h0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".re"},    O_IMem_Re,   0);
        chk({tag, ".addr"},  O_IMem_Addr, 0);
        chk({tag, ".valid"}, O_Valid,     0);
        chk({tag, ".pc"},    O_PC,        0);
        chk({tag, ".flush"}, O_Flush,     0);
        chk({tag, ".busy"},  O_Busy,      0);
        chk({tag, ".term"},  O_Term,      0);
    endtask

    initial begin
        reset = 1'b1; I_Start = 1'b0; I_Start_Addr = '0; I_End_Addr = '0;
        I_Stall = 1'b0; I_Branch = 1'b0; I_Branch_Addr = '0; I_End = 1'b0;
        step(1'b1, 1'b0, 10'h0, 10'h0, 1'b0, 1'b0, 10'h0, 1'b0);
        step(1'b1, 1'b0, 10'h0, 10'h0, 1'b0, 1'b0, 10'h0, 1'b0);
        quiet();
        chk_all_zero("reset");

        // Straight-line program 0x010..0x013
        step(1'b0, 1'b1, 10'h010, 10'h013, 1'b0, 1'b0, 10'h0, 1'b0);
        chk("t1.start_busy", O_Busy, 0);
        for (int i = 0; i < 4; i++) begin
            quiet();
            chk("t1.re",   O_IMem_Re,   1);
            chk("t1.addr", O_IMem_Addr, 10'h010 + i);
            chk("t1.valid", O_Valid, (i > 0) ? 1 : 0);
            if (i > 0) chk("t1.pc", O_PC, 10'h010 + i - 1);
        end
        quiet();
        chk("t1.hold_re",    O_IMem_Re, 0);
        chk("t1.last_valid", O_Valid,   1);
        chk("t1.last_pc",    O_PC,      10'h013);
        chk("t1.hold_busy",  O_Busy,    1);
        quiet();
        chk("t1.hold_re2",    O_IMem_Re, 0);
        chk("t1.hold_valid2", O_Valid,   0);
        chk("t1.hold_addr",   O_IMem_Addr, 10'h013);
        step(1'b0, 1'b0, 10'h0, 10'h0, 1'b0, 1'b0, 10'h0, 1'b1);
        chk("t1.end_flush", O_Flush, 0);
        chk("t1.end_term",  O_Term,  0);
        quiet();
        chk("t1.term",      O_Term, 1);
        chk("t1.term_busy", O_Busy, 1);
        quiet();
        chk("t1.idle_term", O_Term, 0);
        chk("t1.idle_busy", O_Busy, 0);

        // Stall after first issue, then branch, start-while-busy, end+branch
        step(1'b0, 1'b1, 10'h010, 10'h013, 1'b0, 1'b0, 10'h0, 1'b0);
        quiet();
        chk("t2.re0",   O_IMem_Re,   1);
        chk("t2.addr0", O_IMem_Addr, 10'h010);
        step(1'b0, 1'b0, 10'h0, 10'h0, 1'b1, 1'b0, 10'h0, 1'b0);
        chk("t2.stall_re",    O_IMem_Re,   0);
        chk("t2.stall_addr",  O_IMem_Addr, 10'h011);
        chk("t2.stall_valid", O_Valid,     1);
        chk("t2.stall_pc",    O_PC,        10'h010);
        step(1'b0, 1'b0, 10'h0, 10'h0, 1'b1, 1'b0, 10'h0, 1'b0);
        chk("t2.stall2_re",    O_IMem_Re, 0);
        chk("t2.stall2_valid", O_Valid,   0);
        quiet();
        chk("t2.resume_re",   O_IMem_Re,   1);
        chk("t2.resume_addr", O_IMem_Addr, 10'h011);
        step(1'b0, 1'b0, 10'h0, 10'h0, 1'b0, 1'b1, 10'h080, 1'b0);
        chk("t3.flush",    O_Flush,   1);
        chk("t3.squash",   O_Valid,   0);
        chk("t3.br_re",    O_IMem_Re, 0);
        step(1'b0, 1'b1, 10'h200, 10'h210, 1'b0, 1'b0, 10'h0, 1'b0);
        chk("t3.tgt_re",    O_IMem_Re,   1);
        chk("t3.tgt_addr",  O_IMem_Addr, 10'h080);
        chk("t3.tgt_flush", O_Flush,     0);
        chk("t3.tgt_valid", O_Valid,     0);
        quiet();
        chk("t6.ign_start_addr", O_IMem_Addr, 10'h081);
        chk("t3.tgt_wvalid",     O_Valid,     1);
        chk("t3.tgt_wpc",        O_PC,        10'h080);
        step(1'b0, 1'b0, 10'h0, 10'h0, 1'b0, 1'b1, 10'h300, 1'b1);
        chk("t5.flush", O_Flush,   0);
        chk("t5.valid", O_Valid,   0);
        chk("t5.re",    O_IMem_Re, 0);
        chk("t5.term0", O_Term,    0);
        quiet();
        chk("t5.term",       O_Term,  1);
        chk("t5.term_flush", O_Flush, 0);
        chk("t5.term_busy",  O_Busy,  1);
        quiet();
        chk("t5.idle_term", O_Term, 0);
        chk("t5.idle_busy", O_Busy, 0);

        // Wrapped program 0x3FE..0x001
        step(1'b0, 1'b1, 10'h3FE, 10'h001, 1'b0, 1'b0, 10'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            quiet();
            chk("t4.re",   O_IMem_Re,   1);
            chk("t4.addr", O_IMem_Addr, (10'h3FE + i) & 10'h3FF);
            if (i > 0) chk("t4.pc", O_PC, (10'h3FE + i - 1) & 10'h3FF);
        end
        step(1'b0, 1'b0, 10'h0, 10'h0, 1'b0, 1'b1, 10'h100, 1'b0);
        chk("t4.hold_re",    O_IMem_Re, 0);
        chk("t4.hold_flush", O_Flush,   1);
        chk("t4.hold_squash", O_Valid,  0);
        quiet();
        chk("t4.redir_re",   O_IMem_Re,   1);
        chk("t4.redir_addr", O_IMem_Addr, 10'h100);

        // Reset with a read in flight
        step(1'b1, 1'b0, 10'h0, 10'h0, 1'b0, 1'b0, 10'h0, 1'b0);
        chk("t6.rst_valid", O_Valid, 0);
        quiet();
        chk_all_zero("t6.after_rst");

        // Start == End: one issue then HOLD
        step(1'b0, 1'b1, 10'h055, 10'h055, 1'b0, 1'b0, 10'h0, 1'b0);
        quiet();
        chk("se.re",   O_IMem_Re,   1);
        chk("se.addr", O_IMem_Addr, 10'h055);
        quiet();
        chk("se.hold_re", O_IMem_Re, 0);
        chk("se.valid",   O_Valid,   1);
        chk("se.pc",      O_PC,      10'h055);
        chk("se.busy",    O_Busy,    1);
        step(1'b0, 1'b0, 10'h0, 10'h0, 1'b0, 1'b0, 10'h0, 1'b1);
        quiet();
        chk("se.term", O_Term, 1);
        quiet();
        chk("se.idle", O_Busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
